// File: rtl/sfp_dispatch_pkg.sv
// Shared types and default sizing for the SFP dispatch scheduler.
package sfp_dispatch_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARB      = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

endpackage

// File: rtl/sfp_rr_arb.sv
// Rotating-priority selector: lowest pending index at or above rr_ptr, wrapping.
module sfp_rr_arb #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  logic [CH_W:0]   sum  [NUM_CH];
  logic [CH_W-1:0] cand [NUM_CH];

  // cand[k] is the channel visited k steps after rr_ptr; rr_ptr < NUM_CH so one subtract wraps
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
    assign sum[gi]  = {1'b0, rr_ptr} + (CH_W+1)'(gi);
    assign cand[gi] = (sum[gi] >= (CH_W+1)'(NUM_CH))
                      ? CH_W'(sum[gi] - (CH_W+1)'(NUM_CH))
                      : sum[gi][CH_W-1:0];
  end

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending[cand[k]]) begin
        any = 1'b1;
        idx = cand[k];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/sfp_dispatch_sched.sv
// SFP queue dispatch scheduler: latch mode mirrors the valid vector, round-robin mode
// grants each pending queue for a burst of ready beats with one idle cycle between grants.
module sfp_dispatch_sched
  import sfp_dispatch_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              kernel_send_start,
  input  logic [NUM_CH-1:0] qune_send_vaild,
  input  logic              cfg_mode,
  input  logic [CNT_W-1:0]  cfg_burst_len,
  input  logic              sfp_ready,
  output logic [NUM_CH-1:0] sfp_dispatch_en,
  output logic [CH_W-1:0]   sfp_dispatch_ch,
  output logic              busy,
  output logic              round_done,
  output logic              start_drop
);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              busy_q, busy_d;
  logic              round_done_q, round_done_d;
  logic              start_drop_q, start_drop_d;

  logic [NUM_CH-1:0] arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;
  logic              last_beat;
  logic [NUM_CH-1:0] pending_left;
  logic [CNT_W-1:0]  burst_eff;

  sfp_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  assign last_beat    = sfp_ready && (cnt_q == CNT_W'(1));
  assign pending_left = pending_q & ~en_q;
  assign burst_eff    = (cfg_burst_len == '0) ? CNT_W'(1) : cfg_burst_len;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= ST_IDLE;
      en_q         <= '0;
      ch_q         <= '0;
      cnt_q        <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      start_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      round_done_q <= round_done_d;
      start_drop_q <= start_drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (kernel_send_start && cfg_mode && (|qune_send_vaild)) state_d = ST_ARB;
      ST_ARB:      state_d = arb_any ? ST_DISPATCH : ST_IDLE;
      ST_DISPATCH: if (last_beat) state_d = (|pending_left) ? ST_ARB : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d         = en_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;
    round_done_d = 1'b0;
    start_drop_d = kernel_send_start && (state_q != ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (kernel_send_start) begin
          if (cfg_mode) begin
            en_d      = '0;
            pending_d = qune_send_vaild;
          end else begin
            en_d = qune_send_vaild;
          end
        end
      end
      ST_ARB: begin
        en_d  = arb_grant;
        ch_d  = arb_idx;
        cnt_d = arb_any ? burst_eff : '0;
      end
      ST_DISPATCH: begin
        if (last_beat) begin
          en_d         = '0;
          cnt_d        = '0;
          pending_d    = pending_left;
          rr_ptr_d     = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
          round_done_d = ~(|pending_left);
        end else if (sfp_ready) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign sfp_dispatch_en = en_q;
  assign sfp_dispatch_ch = ch_q;
  assign busy            = busy_q;
  assign round_done      = round_done_q;
  assign start_drop      = start_drop_q;

endmodule

// File: tb/tb_sfp_dispatch_sched.sv
// Directed bench for sfp_dispatch_sched; a negedge monitor checks each grant against a scoreboard.
module tb_sfp_dispatch_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [15:0]     len;
  } grant_t;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              kernel_send_start = 1'b0;
  logic [NUM_CH-1:0] qune_send_vaild = '0;
  logic              cfg_mode = 1'b0;
  logic [CNT_W-1:0]  cfg_burst_len = '0;
  logic              sfp_ready = 1'b1;
  logic [NUM_CH-1:0] sfp_dispatch_en;
  logic [CH_W-1:0]   sfp_dispatch_ch;
  logic              busy;
  logic              round_done;
  logic              start_drop;

  int n_checks = 0;
  int n_fail   = 0;
  grant_t exp_q[$];

  sfp_dispatch_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .ap_clk            (ap_clk),
    .ap_rst            (ap_rst),
    .kernel_send_start (kernel_send_start),
    .qune_send_vaild   (qune_send_vaild),
    .cfg_mode          (cfg_mode),
    .cfg_burst_len     (cfg_burst_len),
    .sfp_ready         (sfp_ready),
    .sfp_dispatch_en   (sfp_dispatch_en),
    .sfp_dispatch_ch   (sfp_dispatch_ch),
    .busy              (busy),
    .round_done        (round_done),
    .start_drop        (start_drop)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input int ch, input int len);
    grant_t g;
    g.ch  = CH_W'(ch);
    g.len = 16'(len);
    exp_q.push_back(g);
  endtask

  task automatic start_rr(input logic [NUM_CH-1:0] vld, input int burst);
    cfg_mode          = 1'b1;
    cfg_burst_len     = CNT_W'(burst);
    qune_send_vaild   = vld;
    kernel_send_start = 1'b1;
    tick();
    kernel_send_start = 1'b0;
    qune_send_vaild   = '0;
  endtask

  task automatic run_round(input string tag, input int max_cyc);
    int  done_cnt = 0;
    bit  ended = 1'b0;
    for (int i = 0; i < max_cyc && !ended; i++) begin
      tick();
      if (round_done) done_cnt++;
      if (!busy) ended = 1'b1;
    end
    check({tag, "_ended"}, 32'(ended), 32'd1);
    tick();
    if (round_done) done_cnt++;
    check({tag, "_round_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},         32'(sfp_dispatch_en), 32'd0);
    check({tag, "_ch"},         32'(sfp_dispatch_ch), 32'd0);
    check({tag, "_busy"},       32'(busy),            32'd0);
    check({tag, "_round_done"}, 32'(round_done),      32'd0);
    check({tag, "_start_drop"}, 32'(start_drop),      32'd0);
  endtask

  // Grant monitor: a grant is a run of cycles with busy and a nonzero enable
  logic [NUM_CH-1:0] mon_en;
  logic [CH_W-1:0]   mon_ch;
  int                mon_len = 0;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      mon_len = 0;
    end else if (busy && sfp_dispatch_en != '0) begin
      if (mon_len == 0) begin
        mon_en = sfp_dispatch_en;
        mon_ch = sfp_dispatch_ch;
      end
      mon_len++;
    end else if (mon_len != 0) begin
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 32'(mon_ch), 32'hffff_ffff);
      end else begin
        grant_t g;
        g = exp_q.pop_front();
        check("grant_ch",     32'(mon_ch),  32'(g.ch));
        check("grant_onehot", 32'(mon_en),  32'(4'b0001 << g.ch));
        check("grant_len",    32'(mon_len), 32'(g.len));
        $display("grant ch=%0d en=%b len=%0d (expected ch=%0d len=%0d)",
                 mon_ch, mon_en, mon_len, g.ch, g.len);
      end
      mon_len = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check_all_zero("reset");
    tick();
    tick();
    ap_rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Latch mode: enable mirrors valid and holds after valid drops
    cfg_mode          = 1'b0;
    qune_send_vaild   = 4'b1010;
    kernel_send_start = 1'b1;
    tick();
    kernel_send_start = 1'b0;
    qune_send_vaild   = 4'b0000;
    check("latch_en",   32'(sfp_dispatch_en), 32'b1010);
    check("latch_busy", 32'(busy),            32'd0);
    tick();
    tick();
    check("latch_hold", 32'(sfp_dispatch_en), 32'b1010);

    // Round-robin, burst 3, valid cleared right after the sampling edge
    push(0, 3); push(1, 3); push(3, 3);
    start_rr(4'b1011, 3);
    check("rr_arb_busy", 32'(busy),            32'd1);
    check("rr_arb_en",   32'(sfp_dispatch_en), 32'd0);
    tick();
    check("rr_first_en", 32'(sfp_dispatch_en), 32'b0001);
    check("rr_first_ch", 32'(sfp_dispatch_ch), 32'd0);
    run_round("rr3", 60);

    // Backpressure: ready low 4 cycles mid-grant stretches a 2-beat grant to 6 cycles
    push(1, 6);
    start_rr(4'b0010, 2);
    tick();
    check("bp_en", 32'(sfp_dispatch_en), 32'b0010);
    tick();
    sfp_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_frozen_en", 32'(sfp_dispatch_en), 32'b0010);
    sfp_ready = 1'b1;
    run_round("bp", 20);

    // Wrap and fairness with 1-beat grants (burst_len 0)
    push(3, 1);
    start_rr(4'b1000, 0);
    run_round("wrap_a", 20);
    push(0, 1); push(3, 1);
    start_rr(4'b1001, 0);
    run_round("wrap_b", 20);
    push(0, 1);
    start_rr(4'b0001, 0);
    run_round("wrap_c", 20);
    push(3, 1); push(0, 1);
    start_rr(4'b1001, 0);
    run_round("wrap_d", 20);

    // Start while busy is dropped and leaves the round untouched
    push(1, 2); push(2, 2);
    start_rr(4'b0110, 2);
    tick();
    kernel_send_start = 1'b1;
    qune_send_vaild   = 4'b1111;
    tick();
    kernel_send_start = 1'b0;
    qune_send_vaild   = 4'b0000;
    check("drop_pulse", 32'(start_drop), 32'd1);
    tick();
    check("drop_clear", 32'(start_drop), 32'd0);
    run_round("drop", 30);

    // Round-robin start with nothing valid stays idle
    start_rr(4'b0000, 2);
    check("empty_busy", 32'(busy),            32'd0);
    check("empty_en",   32'(sfp_dispatch_en), 32'd0);
    tick();
    check("empty_no_done", 32'(round_done), 32'd0);

    // Asynchronous reset mid-dispatch, then ch2 granted first
    push(3, 5);
    start_rr(4'b1000, 5);
    tick();
    tick();
    check("pre_rst_en", 32'(sfp_dispatch_en), 32'b1000);
    #2;
    ap_rst = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("mid_rst");
    tick();
    ap_rst = 1'b0;
    tick();
    check_all_zero("rst_release");
    push(2, 1);
    start_rr(4'b0100, 1);
    tick();
    check("post_rst_ch", 32'(sfp_dispatch_ch), 32'd2);
    run_round("post_rst", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
